// File: rtl/matrix_pkg.sv
// Shared sizing defaults and loader state encoding for the matrix-multiply datapath.
package matrix_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ROWS   = 4;
  localparam int DEF_INNER  = 8;
  localparam int DEF_COLS   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD_A = 2'b01,
    LOAD_X = 2'b10,
    DONE   = 2'b11
  } load_state_t;

  // One counter walks both phases, so it is sized for the larger matrix.
  function automatic int cnt_width(input int a_n, input int x_n);
    return $clog2((a_n > x_n) ? a_n : x_n);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_ROWS * DEF_INNER, DEF_INNER * DEF_COLS);

endpackage

// File: rtl/loader_regfile.sv
// A (row-major) and X (column-major) operand banks, written by stream index,
// with a one-cycle registered read port that returns pre-write data on collisions.
module loader_regfile
  import matrix_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS   = DEF_ROWS,
  parameter int INNER  = DEF_INNER,
  parameter int COLS   = DEF_COLS,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic                       sel_x_i,
  input  logic [CNT_W-1:0]           cnt_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [$clog2(INNER)-1:0]   rd_k_i,
  input  logic [$clog2(COLS)-1:0]    rd_col_i,
  output logic [ROWS*DATA_W-1:0]     a_col_o,
  output logic [DATA_W-1:0]          x_o
);

  localparam int A_N  = ROWS * INNER;
  localparam int X_N  = INNER * COLS;
  localparam int AI_W = $clog2(A_N);
  localparam int XI_W = $clog2(X_N);

  // Stream order equals flat storage order: A[r][k] at r*INNER+k, X[k][c] at c*INNER+k.
  logic [DATA_W-1:0]      a_q [A_N];
  logic [DATA_W-1:0]      x_q [X_N];
  logic [ROWS*DATA_W-1:0] a_col_q, a_col_d;
  logic [DATA_W-1:0]      x_out_q, x_out_d;

  always_comb begin
    a_col_d = '0;
    x_out_d = '0;
    if (int'(rd_k_i) < INNER) begin
      for (int r = 0; r < ROWS; r++) begin
        a_col_d[r*DATA_W +: DATA_W] = a_q[AI_W'(r * INNER + int'(rd_k_i))];
      end
      if (int'(rd_col_i) < COLS) begin
        x_out_d = x_q[XI_W'(int'(rd_col_i) * INNER + int'(rd_k_i))];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < A_N; i++) a_q[i] <= '0;
      for (int i = 0; i < X_N; i++) x_q[i] <= '0;
      a_col_q <= '0;
      x_out_q <= '0;
    end else begin
      if (we_i && !sel_x_i && int'(cnt_i) < A_N) a_q[AI_W'(cnt_i)] <= wdata_i;
      if (we_i && sel_x_i && int'(cnt_i) < X_N)  x_q[XI_W'(cnt_i)] <= wdata_i;
      a_col_q <= a_col_d;
      x_out_q <= x_out_d;
    end
  end

  assign a_col_o = a_col_q;
  assign x_o     = x_out_q;

endmodule

// File: rtl/input_loader.sv
// Streams matrix A then X into the operand banks under valid/ready, pulses xload_done
// once both are complete; ready is a pure state decode, so a stalled valid only pauses.
module input_loader
  import matrix_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS   = DEF_ROWS,
  parameter int INNER  = DEF_INNER,
  parameter int COLS   = DEF_COLS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       input_load_en,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  output logic                       xload_done,
  input  logic [$clog2(INNER)-1:0]   rd_k,
  input  logic [$clog2(COLS)-1:0]    rd_col,
  output logic [ROWS*DATA_W-1:0]     a_col_out,
  output logic [DATA_W-1:0]          x_out
);

  localparam int CNT_W = cnt_width(ROWS * INNER, INNER * COLS);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ROWS * INNER - 1);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(INNER * COLS - 1);

  load_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign data_ready = (state_q == LOAD_A) || (state_q == LOAD_X);
  assign xload_done = (state_q == DONE);
  assign accept     = data_valid && data_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (input_load_en) state_d = LOAD_A;
      end
      LOAD_A: begin
        if (!input_load_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          if (cnt_q == A_LAST) begin
            state_d = LOAD_X;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      LOAD_X: begin
        if (!input_load_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          if (cnt_q == X_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE; // DONE lasts one cycle regardless of input_load_en
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  loader_regfile #(
    .DATA_W (DATA_W),
    .ROWS   (ROWS),
    .INNER  (INNER),
    .COLS   (COLS),
    .CNT_W  (CNT_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (accept),
    .sel_x_i  (state_q == LOAD_X),
    .cnt_i    (cnt_q),
    .wdata_i  (data_in),
    .rd_k_i   (rd_k),
    .rd_col_i (rd_col),
    .a_col_o  (a_col_out),
    .x_o      (x_out)
  );

endmodule

// File: tb/tb_input_loader.sv
// Bench for input_loader: randomized streams against a matrix-level reference model.
module tb_input_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        input_load_en, data_valid, data_ready, xload_done;
  logic [7:0]  data_in, x_out;
  logic [2:0]  rd_k;
  logic [1:0]  rd_col;
  logic [31:0] a_col_out;

  logic        en3, dv3, rdy3, done3;
  logic [7:0]  din3, x3;
  logic [2:0]  rk3;
  logic [1:0]  rc3;
  logic [31:0] a3;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_a [4][8];
  logic [7:0] exp_x [8][4];
  logic [7:0] vals [128];
  int         pulse_q [$];

  always #5 clk = ~clk;

  input_loader dut (
    .clk(clk), .rst(rst), .input_load_en(input_load_en), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .xload_done(xload_done),
    .rd_k(rd_k), .rd_col(rd_col), .a_col_out(a_col_out), .x_out(x_out)
  );

  input_loader #(.COLS(3)) dut3 (
    .clk(clk), .rst(rst), .input_load_en(en3), .data_in(din3),
    .data_valid(dv3), .data_ready(rdy3), .xload_done(done3),
    .rd_k(rk3), .rd_col(rc3), .a_col_out(a3), .x_out(x3)
  );

  // Element i of a load: first 32 fill A row-major, next 32 fill X column-major.
  task automatic model_write(input int i, input logic [7:0] v);
    if (i < 32) exp_a[i / 8][i % 8] = v;
    else exp_x[(i - 32) % 8][(i - 32) / 8] = v;
  endtask

  task automatic model_clear();
    for (int r = 0; r < 4; r++) for (int k = 0; k < 8; k++) exp_a[r][k] = '0;
    for (int k = 0; k < 8; k++) for (int c = 0; c < 4; c++) exp_x[k][c] = '0;
  endtask

  function automatic logic [31:0] exp_col(input int k);
    logic [31:0] v;
    for (int r = 0; r < 4; r++) v[r*8 +: 8] = exp_a[r][k];
    return v;
  endfunction

  task automatic read_port(input int k, input int c, output logic [31:0] a, output logic [7:0] x);
    @(negedge clk);
    rd_k = 3'(k);
    rd_col = 2'(c);
    @(posedge clk);
    @(negedge clk);
    a = a_col_out;
    x = x_out;
  endtask

  // Streams vals[] with random valid gaps; records pulse cycle numbers where cycle 1
  // is the cycle in which input_load_en is first high.
  task automatic run_load(input int total, input int gap_pct, input int abort_after,
                          input int want_pulses, output int pulses, output int accepted);
    int n, idle_cyc, budget;
    bit hs;
    pulses = 0;
    accepted = 0;
    idle_cyc = 0;
    budget = 0;
    pulse_q.delete();
    @(negedge clk);
    input_load_en = 1'b1;
    n = 1;
    while (idle_cyc < 3 && budget < 3000) begin
      if (xload_done) begin
        pulses++;
        pulse_q.push_back(n);
        if (pulses >= want_pulses) input_load_en = 1'b0;
      end
      if (abort_after >= 0 && accepted == abort_after) input_load_en = 1'b0;
      if (!input_load_en) idle_cyc++;
      data_valid = input_load_en && (accepted < total) && ($urandom_range(99) >= gap_pct);
      data_in = data_valid ? vals[accepted] : 8'($urandom);
      hs = data_valid && data_ready;
      @(posedge clk);
      if (hs) begin
        model_write(accepted % 64, vals[accepted]);
        accepted++;
      end
      @(negedge clk);
      n++;
      budget++;
    end
    data_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] a;
    logic [7:0] x;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", data_ready); end
    checks++; if (xload_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", xload_done); end
    checks++; if (a_col_out !== 32'h0) begin failures++; $display("FAIL reset_acol got=%h want=0", a_col_out); end
    checks++; if (x_out !== 8'h0) begin failures++; $display("FAIL reset_x got=%h want=0", x_out); end
    rst = 1'b1;
    @(negedge clk);
    input_load_en = 1'b1;
    data_valid = 1'b1;
    data_in = 8'hA5;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      data_in = 8'($urandom_range(1, 255));
    end
    checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL midload_ready got=%b want=1", data_ready); end
    #2 rst = 1'b0;
    #1;
    checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL async_ready got=%b want=0", data_ready); end
    checks++; if (xload_done !== 1'b0) begin failures++; $display("FAIL async_done got=%b want=0", xload_done); end
    checks++; if (a_col_out !== 32'h0) begin failures++; $display("FAIL async_acol got=%h want=0", a_col_out); end
    checks++; if (x_out !== 8'h0) begin failures++; $display("FAIL async_x got=%h want=0", x_out); end
    input_load_en = 1'b0;
    data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    read_port(0, 0, a, x);
    checks++; if (a !== 32'h0) begin failures++; $display("FAIL cleared_acol got=%h want=0", a); end
  endtask

  task automatic test_full_load();
    int pulses, acc;
    logic [31:0] a;
    logic [7:0] x;
    for (int i = 0; i < 64; i++) vals[i] = 8'(i + 1);
    run_load(64, 0, -1, 1, pulses, acc);
    checks++; if (pulses !== 1) begin failures++; $display("FAIL full_pulses got=%0d want=1", pulses); end
    checks++; if (pulses == 0 || pulse_q[0] !== 66) begin failures++; $display("FAIL full_latency got=%0d want=66", pulses ? pulse_q[0] : -1); end
    read_port(0, 0, a, x);
    checks++; if (a[15:8] !== 8'd9) begin failures++; $display("FAIL A10 got=%0d want=9", a[15:8]); end
    read_port(0, 1, a, x);
    checks++; if (x !== 8'd41) begin failures++; $display("FAIL X01 got=%0d want=41", x); end
    read_port(7, 3, a, x);
    checks++; if (x !== 8'd64) begin failures++; $display("FAIL X73 got=%0d want=64", x); end
    for (int k = 0; k < 8; k++) for (int c = 0; c < 4; c++) begin
      read_port(k, c, a, x);
      checks++; if (x !== exp_x[k][c]) begin failures++; $display("FAIL full_x k=%0d c=%0d got=%0d want=%0d", k, c, x, exp_x[k][c]); end
      if (c == 0) begin
        checks++; if (a !== exp_col(k)) begin failures++; $display("FAIL full_a k=%0d got=%h want=%h", k, a, exp_col(k)); end
      end
    end
  endtask

  task automatic test_gaps();
    int pulses, acc;
    logic [31:0] a;
    logic [7:0] x;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    run_load(64, 50, -1, 1, pulses, acc);
    checks++; if (pulses !== 1) begin failures++; $display("FAIL gap_pulses got=%0d want=1", pulses); end
    checks++; if (acc !== 64) begin failures++; $display("FAIL gap_accepted got=%0d want=64", acc); end
    for (int k = 0; k < 8; k++) for (int c = 0; c < 4; c++) begin
      read_port(k, c, a, x);
      checks++; if (x !== 8'(c * 8 + k + 33)) begin failures++; $display("FAIL gap_x k=%0d c=%0d got=%0d want=%0d", k, c, x, c * 8 + k + 33); end
      if (c == 0) begin
        checks++; if (a !== exp_col(k)) begin failures++; $display("FAIL gap_a k=%0d got=%h want=%h", k, a, exp_col(k)); end
      end
    end
  endtask

  task automatic test_abort();
    int pulses, acc;
    logic [31:0] a;
    logic [7:0] x;
    for (int i = 0; i < 64; i++) vals[i] = 8'($urandom);
    run_load(64, 30, 20, 0, pulses, acc);
    checks++; if (pulses !== 0) begin failures++; $display("FAIL abort_pulses got=%0d want=0", pulses); end
    checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL abort_ready got=%b want=0", data_ready); end
    for (int k = 0; k < 8; k++) begin
      read_port(k, 0, a, x);
      checks++; if (a !== exp_col(k)) begin failures++; $display("FAIL partial_a k=%0d got=%h want=%h", k, a, exp_col(k)); end
    end
    for (int i = 0; i < 64; i++) vals[i] = 8'($urandom);
    run_load(64, 20, -1, 1, pulses, acc);
    checks++; if (pulses !== 1) begin failures++; $display("FAIL reload_pulses got=%0d want=1", pulses); end
    for (int k = 0; k < 8; k++) for (int c = 0; c < 4; c++) begin
      read_port(k, c, a, x);
      checks++; if (x !== exp_x[k][c]) begin failures++; $display("FAIL reload_x k=%0d c=%0d got=%0d want=%0d", k, c, x, exp_x[k][c]); end
      if (c == 0) begin
        checks++; if (a !== exp_col(k)) begin failures++; $display("FAIL reload_a k=%0d got=%h want=%h", k, a, exp_col(k)); end
      end
    end
  endtask

  // Read port fixed at (k=2,col=0) across a whole load: each cycle must show
  // the contents as they were before the previous edge.
  task automatic test_read_during_load();
    logic [31:0] snap_a;
    logic [7:0] snap_x;
    int acc, extra, budget;
    bit hs, seen;
    for (int i = 0; i < 64; i++) vals[i] = 8'($urandom);
    @(negedge clk);
    rd_k = 3'd2;
    rd_col = 2'd0;
    snap_a = exp_col(2);
    snap_x = exp_x[2][0];
    @(posedge clk);
    @(negedge clk);
    input_load_en = 1'b1;
    acc = 0; extra = 0; budget = 0; seen = 1'b0;
    while (extra < 2 && budget < 500) begin
      checks++; if (a_col_out !== snap_a) begin failures++; $display("FAIL rdload_a cyc=%0d got=%h want=%h", budget, a_col_out, snap_a); end
      checks++; if (x_out !== snap_x) begin failures++; $display("FAIL rdload_x cyc=%0d got=%h want=%h", budget, x_out, snap_x); end
      if (xload_done) begin seen = 1'b1; input_load_en = 1'b0; end
      if (seen) extra++;
      snap_a = exp_col(2);
      snap_x = exp_x[2][0];
      data_valid = input_load_en && acc < 64;
      data_in = vals[acc % 64];
      hs = data_valid && data_ready;
      @(posedge clk);
      if (hs) begin model_write(acc, vals[acc]); acc++; end
      @(negedge clk);
      budget++;
    end
    data_valid = 1'b0;
    checks++; if (!seen) begin failures++; $display("FAIL rdload_pulse got=0 want=1"); end
  endtask

  task automatic test_back_to_back();
    int pulses, acc, cnt3;
    bit hs, seen;
    logic [31:0] a;
    logic [7:0] x;
    for (int i = 0; i < 128; i++) vals[i] = 8'($urandom);
    run_load(128, 0, -1, 2, pulses, acc);
    checks++; if (pulses !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d want=2", pulses); end
    checks++; if (pulses < 2 || pulse_q[0] !== 66 || pulse_q[1] - pulse_q[0] !== 66) begin
      failures++; $display("FAIL b2b_spacing got=%0d,%0d want=66,132", pulses > 0 ? pulse_q[0] : -1, pulses > 1 ? pulse_q[1] : -1);
    end
    read_port(5, 3, a, x);
    checks++; if (x !== vals[64 + 32 + 29]) begin failures++; $display("FAIL b2b_x got=%0d want=%0d", x, vals[125]); end
    checks++; if (a !== {vals[64+29], vals[64+21], vals[64+13], vals[64+5]}) begin failures++; $display("FAIL b2b_a got=%h", a); end

    en3 = 1'b1; cnt3 = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      @(negedge clk);
      if (done3) begin seen = 1'b1; en3 = 1'b0; end
      dv3 = en3 && cnt3 < 56;
      din3 = 8'(cnt3 + 1);
      hs = dv3 && rdy3;
      @(posedge clk);
      if (hs) cnt3++;
    end
    dv3 = 1'b0;
    en3 = 1'b0;
    checks++; if (!seen) begin failures++; $display("FAIL cols3_pulse got=0 want=1"); end
    @(negedge clk);
    rk3 = 3'd5; rc3 = 2'd2;
    @(posedge clk);
    @(negedge clk);
    checks++; if (x3 !== 8'd54) begin failures++; $display("FAIL cols3_x52 got=%0d want=54", x3); end
    checks++; if (a3 !== {8'd30, 8'd22, 8'd14, 8'd6}) begin failures++; $display("FAIL cols3_a got=%h want=1e160e06", a3); end
    rc3 = 2'd3;
    @(posedge clk);
    @(negedge clk);
    checks++; if (x3 !== 8'd0) begin failures++; $display("FAIL cols3_oob got=%0d want=0", x3); end
  endtask

  initial begin
    input_load_en = 1'b0; data_valid = 1'b0; data_in = '0; rd_k = '0; rd_col = '0;
    en3 = 1'b0; dv3 = 1'b0; din3 = '0; rk3 = '0; rc3 = '0;
    model_clear();
    test_reset();
    test_full_load();
    test_gaps();
    test_abort();
    test_read_during_load();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
